// File: rtl/mfda_valve_sequencer.sv
// mfda_valve_sequencer: replays a stored valve program onto replicated devices.
// Define MFDA_SEQ_FLUSH_EN to add a timed all-valves flush after each run.
module mfda_valve_sequencer #(
  parameter int NUM_DEVICES  = 2,
  parameter int CTRL_A_W     = 13,
  parameter int CTRL_S_W     = 4,
  parameter int FLUSH_SIZE   = 21,
  parameter int PROG_DEPTH   = 16,
  parameter int STEP_W       = 16,
  parameter int PUMP_DIV     = 8,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0]              prog_addr,
  input  logic [CTRL_A_W+CTRL_S_W+STEP_W+2:0]        prog_data,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic [NUM_DEVICES-1:0]                     dev_en,
  output logic                                       busy,
  output logic                                       done,
  output logic [$clog2(PROG_DEPTH)-1:0]              step_idx,
  output logic [NUM_DEVICES*CTRL_A_W-1:0]            ctrl_a,
  output logic [NUM_DEVICES*CTRL_S_W-1:0]            ctrl_s,
  output logic [NUM_DEVICES*3-1:0]                   pump_a,
  output logic [NUM_DEVICES*2-1:0]                   pump_b,
  output logic [FLUSH_SIZE-1:0]                      flush
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int PW = CTRL_A_W + CTRL_S_W + STEP_W + 3;
  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam int CA_LO = STEP_W;
  localparam int CS_LO = STEP_W + CTRL_A_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

`ifdef MFDA_SEQ_FLUSH_EN
  localparam state_t END_ST = FLUSH;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  logic [FW-1:0] fcnt, fcnt_nx;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t state, state_nx;

  logic [PW-1:0] prog_mem [PROG_DEPTH];
  logic [PW-1:0] w0, w_cur, w_nxt, w_sel;

  logic [AW-1:0]          step_nx;
  logic [STEP_W-1:0]      cnt, cnt_nx;
  logic [NUM_DEVICES-1:0] mask, mask_nx;
  logic [2:0]             pa_ph, pa_ph_nx;
  logic [DW-1:0]          pa_div, pa_div_nx;
  logic                   pb_ph, pb_ph_nx;
  logic [DW-1:0]          pb_div, pb_div_nx;
  logic                   load, fin, flush_end, show;

  logic [CTRL_A_W-1:0]    ca_p;
  logic [CTRL_S_W-1:0]    cs_p;
  logic [2:0]             pa_p;
  logic [1:0]             pb_p;

  logic [NUM_DEVICES*CTRL_A_W-1:0] ctrl_a_nx;
  logic [NUM_DEVICES*CTRL_S_W-1:0] ctrl_s_nx;
  logic [NUM_DEVICES*3-1:0]        pump_a_nx;
  logic [NUM_DEVICES*2-1:0]        pump_b_nx;
  logic [FLUSH_SIZE-1:0]           flush_nx;
  logic                            busy_nx, done_nx;

  function automatic logic [2:0] pa_pat(input logic [2:0] ph);
    logic [2:0] r;
    case (ph)
      3'd0:    r = 3'b101;
      3'd1:    r = 3'b100;
      3'd2:    r = 3'b110;
      3'd3:    r = 3'b010;
      3'd4:    r = 3'b011;
      3'd5:    r = 3'b001;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Program RAM is held untouched by reset; writes only land while not busy.
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE || state == DONE))
      prog_mem[prog_addr] <= prog_data;
  end

  assign w0    = prog_mem[0];
  assign w_cur = prog_mem[step_idx];
  assign w_nxt = prog_mem[step_idx + 1'b1];

  assign fin = (state == RUN) && (cnt == '0) &&
               (w_cur[PW-1] || step_idx == AW'(PROG_DEPTH-1));

`ifdef MFDA_SEQ_FLUSH_EN
  assign flush_end = (fcnt == '0);
`else
  assign flush_end = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step_idx <= '0;
      cnt      <= '0;
      mask     <= '0;
      pa_ph    <= '0;
      pa_div   <= '0;
      pb_ph    <= 1'b0;
      pb_div   <= '0;
`ifdef MFDA_SEQ_FLUSH_EN
      fcnt     <= '0;
`endif
      ctrl_a   <= '0;
      ctrl_s   <= '0;
      pump_a   <= '0;
      pump_b   <= '0;
      flush    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      step_idx <= step_nx;
      cnt      <= cnt_nx;
      mask     <= mask_nx;
      pa_ph    <= pa_ph_nx;
      pa_div   <= pa_div_nx;
      pb_ph    <= pb_ph_nx;
      pb_div   <= pb_div_nx;
`ifdef MFDA_SEQ_FLUSH_EN
      fcnt     <= fcnt_nx;
`endif
      ctrl_a   <= ctrl_a_nx;
      ctrl_s   <= ctrl_s_nx;
      pump_a   <= pump_a_nx;
      pump_b   <= pump_b_nx;
      flush    <= flush_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  always_comb begin : next_state
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (fin) state_nx = END_ST;
      FLUSH:      if (flush_end) state_nx = DONE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_comb begin : datapath
    step_nx   = step_idx;
    cnt_nx    = cnt;
    mask_nx   = mask;
    pa_ph_nx  = pa_ph;
    pa_div_nx = pa_div;
    pb_ph_nx  = pb_ph;
    pb_div_nx = pb_div;
`ifdef MFDA_SEQ_FLUSH_EN
    fcnt_nx   = fcnt;
`endif
    w_sel     = w_cur;
    load      = 1'b0;
    if (abort) begin
      step_nx = '0;
      cnt_nx  = '0;
      mask_nx = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mask_nx   = dev_en;
            step_nx   = '0;
            pa_ph_nx  = '0;
            pa_div_nx = '0;
            pb_ph_nx  = 1'b0;
            pb_div_nx = '0;
            w_sel     = w0;
            load      = 1'b1;
          end
        end
        RUN: begin
          // Pump dividers only count while their step enables them.
          if (w_cur[PW-3]) begin
            if (pa_div == DW'(PUMP_DIV-1)) begin
              pa_div_nx = '0;
              pa_ph_nx  = (pa_ph == 3'd5) ? 3'd0 : pa_ph + 3'd1;
            end else begin
              pa_div_nx = pa_div + 1'b1;
            end
          end
          if (w_cur[PW-2]) begin
            if (pb_div == DW'(PUMP_DIV-1)) begin
              pb_div_nx = '0;
              pb_ph_nx  = ~pb_ph;
            end else begin
              pb_div_nx = pb_div + 1'b1;
            end
          end
          if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
          end else if (!fin) begin
            step_nx = step_idx + 1'b1;
            w_sel   = w_nxt;
            load    = 1'b1;
          end
`ifdef MFDA_SEQ_FLUSH_EN
          if (fin) fcnt_nx = FW'(FLUSH_CYCLES-1);
`endif
        end
        FLUSH: begin
`ifdef MFDA_SEQ_FLUSH_EN
          if (fcnt != '0) fcnt_nx = fcnt - 1'b1;
`endif
        end
      endcase
    end
    if (load) cnt_nx = w_sel[STEP_W-1:0];
  end

  always_comb begin : outputs
    show = (state_nx == RUN);
    ca_p = show ? w_sel[CA_LO +: CTRL_A_W] : '0;
    cs_p = show ? w_sel[CS_LO +: CTRL_S_W] : '0;
    pa_p = (show && w_sel[PW-3]) ? pa_pat(pa_ph_nx) : 3'b000;
    pb_p = (show && w_sel[PW-2]) ? (pb_ph_nx ? 2'b10 : 2'b01) : 2'b00;
    ctrl_a_nx = '0;
    ctrl_s_nx = '0;
    pump_a_nx = '0;
    pump_b_nx = '0;
    for (int d = 0; d < NUM_DEVICES; d++) begin
      if (mask_nx[d]) begin
        ctrl_a_nx[d*CTRL_A_W +: CTRL_A_W] = ca_p;
        ctrl_s_nx[d*CTRL_S_W +: CTRL_S_W] = cs_p;
        pump_a_nx[d*3 +: 3]               = pa_p;
        pump_b_nx[d*2 +: 2]               = pb_p;
      end
    end
    flush_nx = (state_nx == FLUSH) ? '1 : '0;
    busy_nx  = (state_nx == RUN) || (state_nx == FLUSH);
    done_nx  = (state_nx == DONE);
  end

endmodule

// File: tb/tb_mfda_valve_sequencer.sv
// tb_mfda_valve_sequencer: scoreboard bench for mfda_valve_sequencer.
// Honors MFDA_SEQ_FLUSH_EN to expect the flush phase.
module tb_mfda_valve_sequencer;

`ifdef MFDA_SEQ_FLUSH_EN
  localparam int FL = 64;
`else
  localparam int FL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [35:0] prog_data;
  logic        start;
  logic        abort;
  logic [1:0]  dev_en;
  logic        busy;
  logic        done;
  logic [3:0]  step_idx;
  logic [25:0] ctrl_a;
  logic [7:0]  ctrl_s;
  logic [5:0]  pump_a;
  logic [3:0]  pump_b;
  logic [20:0] flush;

  mfda_valve_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .abort(abort), .dev_en(dev_en),
    .busy(busy), .done(done), .step_idx(step_idx), .ctrl_a(ctrl_a),
    .ctrl_s(ctrl_s), .pump_a(pump_a), .pump_b(pump_b), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [25:0] ca;
    logic [7:0]  cs;
    logic [5:0]  pa;
    logic [3:0]  pb;
    logic        bsy;
    logic        dn;
    logic [3:0]  st;
    logic [20:0] fl;
  } snap_t;

  snap_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [2:0] pa_tab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] word(logic last, logic pb, logic pa,
    logic [3:0] cs, logic [12:0] ca, logic [15:0] dw);
    return {last, pb, pa, cs, ca, dw};
  endfunction

  task automatic prog_write(int a, logic [35:0] d);
    prog_we = 1'b1;
    prog_addr = 4'(a);
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic push(string tag, logic [25:0] ca, logic [7:0] cs,
    logic [5:0] pa, logic [3:0] pb, logic bsy, logic dn, logic [3:0] st,
    logic [20:0] fl);
    snap_t s;
    s.tag = tag; s.ca = ca; s.cs = cs; s.pa = pa; s.pb = pb;
    s.bsy = bsy; s.dn = dn; s.st = st; s.fl = fl;
    sb.push_back(s);
  endtask

  task automatic push_end(string tag, logic [3:0] st);
    for (int i = 0; i < FL; i++)
      push({tag, "_fl"}, 0, 0, 0, 0, 1'b1, 1'b0, st, 21'h1FFFFF);
    push(tag, 0, 0, 0, 0, 1'b0, 1'b1, st, 0);
  endtask

  task automatic run_cmp(int n, logic [1:0] en_after);
    snap_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) begin
        start = 1'b0;
        abort = 1'b0;
        prog_we = 1'b0;
        dev_en = en_after;
      end
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_ca"}, 32'(ctrl_a), 32'(e.ca));
        check({e.tag, "_cs"}, 32'(ctrl_s), 32'(e.cs));
        check({e.tag, "_pa"}, 32'(pump_a), 32'(e.pa));
        check({e.tag, "_pb"}, 32'(pump_b), 32'(e.pb));
        check({e.tag, "_busy"}, 32'(busy), 32'(e.bsy));
        check({e.tag, "_done"}, 32'(done), 32'(e.dn));
        check({e.tag, "_step"}, 32'(step_idx), 32'(e.st));
        check({e.tag, "_flush"}, 32'(flush), 32'(e.fl));
      end
    end
  endtask

  function automatic logic [25:0] da(logic [12:0] v);
    return {v, v};
  endfunction

  initial begin
    logic [2:0] p;
    logic [1:0] q;
    rst = 1'b1; prog_we = 0; prog_addr = 0; prog_data = 0;
    start = 0; abort = 0; dev_en = 0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ca", 32'(ctrl_a), 0);
    check("rst_pa", 32'(pump_a), 0);
    check("rst_flush", 32'(flush), 0);
    rst = 1'b0;
    tick();

    // async reset in the middle of a run
    prog_write(0, word(1, 0, 0, 0, 13'h1FFF, 16'd20));
    dev_en = 2'b11;
    for (int i = 0; i < 3; i++)
      push("t1", 26'h3FFFFFF, 0, 0, 0, 1, 0, 0, 0);
    start = 1'b1;
    run_cmp(3, 2'b11);
    #3 rst = 1'b1;
    #1;
    check("t1_async_busy", 32'(busy), 0);
    check("t1_async_ca", 32'(ctrl_a), 0);
    check("t1_async_step", 32'(step_idx), 0);
    tick();
    rst = 1'b0;
    tick();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_done", 32'(done), 0);

    // two-step program with dwell 2 then 0
    prog_write(0, word(0, 0, 0, 4'h0, 13'h1A5, 16'd2));
    prog_write(1, word(1, 0, 0, 4'h9, 13'h0, 16'd0));
    dev_en = 2'b11;
    for (int i = 0; i < 3; i++)
      push("t2_s0", da(13'h1A5), 0, 0, 0, 1, 0, 0, 0);
    push("t2_s1", 0, 8'h99, 0, 0, 1, 0, 1, 0);
    push_end("t2_end", 1);
    start = 1'b1;
    run_cmp(4 + FL + 1, 2'b11);

    // pump phases over 56 cycles: seven phases, one wrap
    prog_write(0, word(1, 1, 1, 0, 0, 16'd55));
    for (int c = 0; c < 56; c++) begin
      p = pa_tab[(c / 8) % 6];
      q = ((c / 8) % 2 == 0) ? 2'b01 : 2'b10;
      push("t3", 0, 0, {p, p}, {q, q}, 1, 0, 0, 0);
    end
    push_end("t3_end", 0);
    start = 1'b1;
    run_cmp(56 + FL + 1, 2'b11);

    // device gating, mask latched at start
    prog_write(0, word(1, 0, 1, 0, 13'h1FFF, 16'd5));
    dev_en = 2'b10;
    for (int i = 0; i < 6; i++)
      push("t4", 26'h3FFE000, 0, 6'b101000, 0, 1, 0, 0, 0);
    push_end("t4_end", 0);
    start = 1'b1;
    run_cmp(6 + FL + 1, 2'b01);

    // abort beats start; writes during a run are dropped
    for (int i = 0; i < 5; i++)
      prog_write(i, word(i == 4, 0, 0, 0, 13'(i + 1), 16'd1));
    dev_en = 2'b11;
    for (int i = 0; i < 6; i++)
      push("t5", da(13'(i / 2 + 1)), 0, 0, 0, 1, 0, 4'(i / 2), 0);
    start = 1'b1;
    run_cmp(2, 2'b11);
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = word(1, 0, 0, 0, 13'h0AA, 16'd0);
    run_cmp(4, 2'b11);
    push("t5_s3", da(13'd4), 0, 0, 0, 1, 0, 3, 0);
    run_cmp(1, 2'b11);
    push("t5_abort", 0, 0, 0, 0, 0, 0, 0, 0);
    push("t5_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    push("t5_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    abort = 1'b1;
    start = 1'b1;
    run_cmp(3, 2'b11);
    for (int i = 0; i < 10; i++)
      push("t5_rb", da(13'(i / 2 + 1)), 0, 0, 0, 1, 0, 4'(i / 2), 0);
    push_end("t5_end", 4);
    start = 1'b1;
    run_cmp(10 + FL + 1, 2'b11);

    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
